// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl -- run controller for the cpu core.
//
// Gates the core's clock-enable so that execution can be started, paused,
// single-stepped, limited to a cycle budget and stopped on PC breakpoints.
// It counts every cycle in which the core was enabled and reports why
// execution last stopped.
//
// Optional feature macro: RUN_CTRL_BP_EN
//   defined   : NUM_BP PC comparators, the resume-skip flag and o_bp_idx.
//   undefined : no comparators; breakpoints never hit, o_bp_idx is tied 0,
//               i_bp_addr / i_bp_valid are accepted but ignored.
//
// Parameters:
//   CNT_W   width of the cycle counter and the cycle limit
//   ADDR_W  width of the PC and breakpoint addresses
//   NUM_BP  number of breakpoint channels (1..16)
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_start        pulse: run (fresh from IDLE/DONE, resume from PAUSED)
//   i_stop         pulse: pause; beats i_start when both are high
//   i_step         pulse: execute exactly one cycle from IDLE/PAUSED
//   i_max_cycles   cycle limit, 0 = unlimited
//   i_pc           PC of the instruction the core will execute next
//   i_cpu_halt     core executed a halt instruction this cycle
//   i_bp_addr      packed breakpoint addresses, channel 0 in the LSBs
//   i_bp_valid     per-channel breakpoint enable
//   o_cpu_en       core clock-enable (combinational)
//   o_cycle_count  number of enabled cycles, saturating
//   o_state        IDLE=0 RUN=1 STEP=2 PAUSED=3 DONE=4
//   o_done         high while in DONE
//   o_cause        0 none, 1 limit, 2 halt, 3 breakpoint
//   o_bp_idx       lowest-index breakpoint channel that hit
// ---------------------------------------------------------------------------
module run_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32,
    parameter int NUM_BP = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_step,
    input  logic [CNT_W-1:0]         i_max_cycles,
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic                     i_cpu_halt,
    input  logic [NUM_BP*ADDR_W-1:0] i_bp_addr,
    input  logic [NUM_BP-1:0]        i_bp_valid,
    output logic                     o_cpu_en,
    output logic [CNT_W-1:0]         o_cycle_count,
    output logic [2:0]               o_state,
    output logic                     o_done,
    output logic [1:0]               o_cause,
    output logic [3:0]               o_bp_idx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_LIMIT = 2'd1,
        CAUSE_HALT  = 2'd2,
        CAUSE_BP    = 2'd3
    } cause_t;

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [3:0]       bp_idx_q, bp_idx_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clear;

    logic             bp_hit_eff;
    logic [3:0]       bp_first;
    logic             limit_hit;

    // -----------------------------------------------------------------------
    // Breakpoint comparators
    // -----------------------------------------------------------------------
`ifdef RUN_CTRL_BP_EN
    logic [NUM_BP-1:0] bp_match;

    always_comb begin
        for (int n = 0; n < NUM_BP; n++) begin
            bp_match[n] = i_bp_valid[n] && (i_pc == i_bp_addr[n*ADDR_W +: ADDR_W]);
        end
    end

    // Scan from the top down so the last assignment is the lowest channel.
    always_comb begin
        bp_first = 4'd0;
        for (int n = NUM_BP - 1; n >= 0; n--) begin
            if (bp_match[n]) begin
                bp_first = 4'(n);
            end
        end
    end

    // The skip flag masks the breakpoint we just resumed from for one cycle.
    assign bp_hit_eff = (|bp_match) && !skip_q;
    assign o_bp_idx   = bp_idx_q;
`else
    logic unused_bp;

    assign bp_first   = 4'd0;
    assign bp_hit_eff = 1'b0;
    assign o_bp_idx   = 4'd0;
    assign unused_bp  = ^{i_bp_addr, i_bp_valid, i_pc, bp_idx_q};
`endif

    // -----------------------------------------------------------------------
    // Cycle limit: compare one bit wider so a saturated counter cannot wrap
    // the comparison, and ">=" covers a limit lowered below the count.
    // -----------------------------------------------------------------------
    logic [CNT_W:0] cnt_plus_one;

    assign cnt_plus_one = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign limit_hit    = (i_max_cycles != '0) && (cnt_plus_one >= {1'b0, i_max_cycles});

    // -----------------------------------------------------------------------
    // State and status registers
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            bp_idx_q <= 4'd0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            bp_idx_q <= bp_idx_d;
            skip_q   <= skip_d;
        end
    end

    // Counter: cleared on a fresh start, otherwise counts enabled cycles
    // and sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clear) begin
            cnt_q <= '0;
        end else if (o_cpu_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        bp_idx_d  = bp_idx_q;
        skip_d    = skip_q;
        cnt_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    cnt_clear = 1'b1;
                end else if (i_step && !i_stop) begin
                    state_d = ST_STEP;
                end
            end

            ST_RUN: begin
                // Skip only ever covers the first cycle after a resume.
                skip_d = 1'b0;
                if (i_stop) begin
                    state_d = ST_PAUSED;
                    cause_d = CAUSE_NONE;
                end else if (bp_hit_eff) begin
                    state_d  = ST_PAUSED;
                    cause_d  = CAUSE_BP;
                    bp_idx_d = bp_first;
                end else if (i_cpu_halt) begin
                    // The core is enabled on this path (no stop, no hit).
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (limit_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                end
            end

            ST_STEP: begin
                if (i_cpu_halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (limit_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                end else begin
                    state_d = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                if (i_start && !i_stop) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (i_step && !i_stop) begin
                    state_d = ST_STEP;
                end
            end

            ST_DONE: begin
                if (i_start && !i_stop) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    cnt_clear = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. o_cpu_en is combinational so a breakpoint or stop blocks the
    // very cycle it appears in, and reset removes it without waiting for
    // an edge.
    // -----------------------------------------------------------------------
    always_comb begin
        o_cpu_en = 1'b0;
        o_done   = 1'b0;
        case (state_q)
            ST_RUN:  o_cpu_en = !bp_hit_eff && !i_stop;
            ST_STEP: o_cpu_en = 1'b1;
            ST_DONE: o_done   = 1'b1;
            default: begin
                o_cpu_en = 1'b0;
                o_done   = 1'b0;
            end
        endcase
    end

    assign o_cycle_count = cnt_q;
    assign o_state       = state_q;
    assign o_cause       = cause_q;

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl -- self-checking bench for run_ctrl.
//
// Inputs change on the falling edge; outputs are compared 1 ns later against
// a behavioural model that keeps the controller's mode, count and cause as
// plain integers and advances them once per rising edge. Directed scenarios
// come first, then a randomized phase.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int CNT_W   = 8;
    localparam int ADDR_W  = 16;
    localparam int NUM_BP  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Model mode numbers, as they appear on o_state.
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DONE   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start, stop, step, halt;
    logic [CNT_W-1:0]         max_cycles;
    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        bp [NUM_BP];
    logic [NUM_BP*ADDR_W-1:0] bp_bus;
    logic [NUM_BP-1:0]        bp_valid;

    logic                     cpu_en;
    logic [CNT_W-1:0]         cycle_count;
    logic [2:0]               state;
    logic                     done;
    logic [1:0]               cause;
    logic [3:0]               bp_idx;

    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < NUM_BP; n++) begin
            bp_bus[n*ADDR_W +: ADDR_W] = bp[n];
        end
    end

    run_ctrl #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_step        (step),
        .i_max_cycles  (max_cycles),
        .i_pc          (pc),
        .i_cpu_halt    (halt),
        .i_bp_addr     (bp_bus),
        .i_bp_valid    (bp_valid),
        .o_cpu_en      (cpu_en),
        .o_cycle_count (cycle_count),
        .o_state       (state),
        .o_done        (done),
        .o_cause       (cause),
        .o_bp_idx      (bp_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int en_seen = 0;

    // Reference model state.
    int m_state;
    int m_cnt;
    int m_cause;
    int m_idx;
    bit m_skip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_cause = 0;
        m_idx   = 0;
        m_skip  = 1'b0;
    endtask

    // Lowest valid channel whose address equals the PC, or -1.
    function automatic int model_bp_idx();
`ifdef RUN_CTRL_BP_EN
        for (int n = 0; n < NUM_BP; n++) begin
            if (bp_valid[n] && (bp[n] == pc)) return n;
        end
`endif
        return -1;
    endfunction

    function automatic bit model_en();
        bit hit;
        hit = (model_bp_idx() >= 0) && !m_skip;
        return ((m_state == M_RUN) && !hit && !stop) || (m_state == M_STEP);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int  hit_idx;
        bit  hit, en, lim, go;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hit_idx = model_bp_idx();
        hit     = (hit_idx >= 0) && !m_skip;
        en      = model_en();
        lim     = (max_cycles != 0) && (m_cnt + 1 >= int'(max_cycles));
        go      = start && !stop;
        case (m_state)
            M_IDLE: begin
                if (go) begin
                    m_state = M_RUN; m_cnt = 0; m_cause = 0;
                end else if (step && !stop) begin
                    m_state = M_STEP;
                end
            end
            M_RUN: begin
                m_skip = 1'b0;
                if (stop) begin
                    m_state = M_PAUSED; m_cause = 0;
                end else if (hit) begin
                    m_state = M_PAUSED; m_cause = 3; m_idx = hit_idx;
                end else if (halt) begin
                    m_state = M_DONE; m_cause = 2;
                end else if (lim) begin
                    m_state = M_DONE; m_cause = 1;
                end
            end
            M_STEP: begin
                if (halt) begin
                    m_state = M_DONE; m_cause = 2;
                end else if (lim) begin
                    m_state = M_DONE; m_cause = 1;
                end else begin
                    m_state = M_PAUSED;
                end
            end
            M_PAUSED: begin
                if (go) begin
                    m_state = M_RUN; m_skip = 1'b1;
                end else if (step && !stop) begin
                    m_state = M_STEP;
                end
            end
            default: begin
                if (go) begin
                    m_state = M_RUN; m_cnt = 0; m_cause = 0;
                end
            end
        endcase
        if (en && (m_cnt < CNT_MAX)) m_cnt++;
    endtask

    task automatic check_outputs();
        check("state",  32'(state),       32'(m_state));
        check("cpu_en", 32'(cpu_en),      32'(model_en()));
        check("done",   32'(done),        32'(m_state == M_DONE));
        check("count",  32'(cycle_count), 32'(m_cnt));
        check("cause",  32'(cause),       32'(m_cause));
        check("bp_idx", 32'(bp_idx),      32'(m_idx));
    endtask

    // Called at a falling edge with inputs already applied; returns at the
    // next falling edge.
    task automatic tick();
        #1;
        if (!rst_n) model_reset();
        check_outputs();
        if (cpu_en) en_seen++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit s, input bit p, input bit st, input bit h);
        start = s; stop = p; step = st; halt = h;
        tick();
        start = 1'b0; stop = 1'b0; step = 1'b0; halt = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        step       = 1'b0;
        halt       = 1'b0;
        max_cycles = '0;
        pc         = 16'h0010;
        bp_valid   = '0;
        for (int n = 0; n < NUM_BP; n++) bp[n] = 16'(16'h0100 + n);
        model_reset();

        // Reset state.
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Cycle limit of 50.
        max_cycles = 8'd50;
        en_seen    = 0;
        drive(1, 0, 0, 0);
        repeat (60) tick();
        check("lim_enables", 32'(en_seen),     32'd50);
        check("lim_state",   32'(state),       32'd4);
        check("lim_done",    32'(done),        32'd1);
        check("lim_cause",   32'(cause),       32'd1);
        check("lim_count",   32'(cycle_count), 32'd50);

        // Halt at count 17, unlimited.
        max_cycles = '0;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 40 && m_cnt != 17; i++) tick();
        drive(0, 0, 0, 1);
        check("halt_state", 32'(state),       32'd4);
        check("halt_cause", 32'(cause),       32'd2);
        check("halt_count", 32'(cycle_count), 32'd18);

        // Stop at 10, then three single steps.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 40 && m_cnt != 10; i++) tick();
        drive(0, 1, 0, 0);
        check("stop_state", 32'(state), 32'd3);
        for (int k = 0; k < 3; k++) begin
            en_seen = 0;
            drive(0, 0, 1, 0);
            tick();
            check("step_enables", 32'(en_seen), 32'd1);
            check("step_state",   32'(state),   32'd3);
        end
        check("step_count", 32'(cycle_count), 32'd13);

`ifdef RUN_CTRL_BP_EN
        // Breakpoints on channels 1 and 3 at 0x40.
        bp[0] = 16'h0080; bp[1] = 16'h0040; bp[2] = 16'h0090; bp[3] = 16'h0040;
        bp_valid = 4'b1010;
        pc = 16'h0010;
        drive(1, 0, 0, 0);
        repeat (3) tick();
        pc = 16'h0040;
        #1 check("bp_block_en", 32'(cpu_en), 32'd0);
        tick();
        check("bp_state", 32'(state),  32'd3);
        check("bp_cause", 32'(cause),  32'd3);
        check("bp_idx",   32'(bp_idx), 32'd1);
        drive(1, 0, 0, 0);
        en_seen = 0;
        tick();
        check("bp_resume_en", 32'(en_seen), 32'd1);
        pc = 16'h0044;
        repeat (3) tick();
        check("bp_run_state", 32'(state), 32'd1);
        drive(0, 1, 0, 0);
        bp_valid = '0;
`endif

        // Asynchronous reset in the middle of a run.
        drive(1, 0, 0, 0);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_cpu_en", 32'(cpu_en),      32'd0);
        check("rst_state",  32'(state),       32'd0);
        check("rst_count",  32'(cycle_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Start+stop together from IDLE and from PAUSED, then saturation.
        drive(1, 1, 0, 0);
        check("ss_idle", 32'(state), 32'd0);
        drive(1, 0, 0, 0);
        repeat (3) tick();
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        check("ss_paused", 32'(state), 32'd3);
        drive(1, 0, 0, 0);
        repeat (300) tick();
        check("sat_count", 32'(cycle_count), 32'(CNT_MAX));
        check("sat_state", 32'(state),       32'd1);

        // Limit lowered below the current count.
        max_cycles = 8'd5;
        tick();
        check("lower_state", 32'(state),       32'd4);
        check("lower_cause", 32'(cause),       32'd1);
        check("lower_count", 32'(cycle_count), 32'(CNT_MAX));

        // Randomized phase.
        for (int n = 0; n < NUM_BP; n++) bp[n] = 16'(16'h0040 + n);
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom % 500) != 0;
            start = ($urandom % 12) == 0;
            stop  = ($urandom % 20) == 0;
            step  = ($urandom % 8) == 0;
            halt  = ($urandom % 40) == 0;
            pc    = (($urandom % 3) == 0) ? 16'(16'h0040 + ($urandom % 4))
                                          : 16'($urandom_range(0, 255));
            if (($urandom % 50) == 0) max_cycles = 8'($urandom_range(0, 60));
            if (($urandom % 30) == 0) bp_valid = 4'($urandom);
            if (($urandom % 200) == 0) bp[$urandom % NUM_BP] = 16'($urandom_range(16'h0040, 16'h0047));
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0; stop = 1'b0; step = 1'b0; halt = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
